// File: rtl/rv32i_types.sv
// Shared types for the L2 line interface and its arbiter.
// Line width here must match the arbiter's s_line parameter.
package rv32i_types;

    localparam int unsigned L2_LINE = 256;

    typedef struct packed {
        logic [31:0]        mem_address;
        logic [L2_LINE-1:0] mem_wdata;
        logic               mem_read;
        logic               mem_write;
    } l2_go_t;

    typedef struct packed {
        logic               mem_resp;
        logic [L2_LINE-1:0] mem_rdata;
    } l2_ret_t;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D,
        DONE
    } l2_arb_state_t;

endpackage

// File: rtl/l2_arb_select.sv
// Tie-break between I and D requests; L2_ARB_RR_EN selects round-robin,
// otherwise D always wins and no last-grant state exists.
module l2_arb_select (
    input  logic clk,
    input  logic rst,
    input  logic i_req,
    input  logic d_req,
    input  logic grant_en,
    output logic grant_d
);

`ifdef L2_ARB_RR_EN
    logic last_d;

    always_comb begin
        grant_d = d_req;
        if (i_req && d_req)
            grant_d = ~last_d;
    end

    always_ff @(posedge clk) begin
        if (rst)
            last_d <= 1'b1;
        else if (grant_en)
            last_d <= grant_d;
    end
`else
    logic unused_sel;
    assign unused_sel = ^{clk, rst, i_req, grant_en};
    assign grant_d    = d_req;
`endif

endmodule

// File: rtl/l2_arbiter.sv
// Arbitrates L1 I/D line misses onto one L2 transaction at a time.
// Tie policy set by L2_ARB_RR_EN (round-robin) or default D priority.
import rv32i_types::*;

module l2_arbiter #(
    parameter int unsigned s_offset = 5,
    parameter int unsigned s_line   = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       i_address,
    input  logic              i_read,
    output logic [s_line-1:0] i_rdata,
    output logic              i_resp,
    input  logic [31:0]       d_address,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [s_line-1:0] d_wdata,
    output logic [s_line-1:0] d_rdata,
    output logic              d_resp,
    output l2_go_t            l2_go,
    input  l2_ret_t           l2_ret
);

    localparam logic [31:0] ADDR_MASK =
        ~((32'd1 << s_offset) - 32'd1);

    l2_arb_state_t state, state_n;
    logic i_req, d_req, grant_en, grant_d;
    logic serving, ret_hit;

    assign i_req    = i_read;
    assign d_req    = d_read | d_write;
    assign grant_en = (state == IDLE) && (i_req || d_req);
    assign serving  = (state == SERVE_I) || (state == SERVE_D);
    assign ret_hit  = serving && l2_ret.mem_resp;

    l2_arb_select u_sel (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_req),
        .d_req    (d_req),
        .grant_en (grant_en),
        .grant_d  (grant_d)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (grant_en)
                    state_n = grant_d ? SERVE_D : SERVE_I;
            end
            SERVE_I, SERVE_D: begin
                if (l2_ret.mem_resp)
                    state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // l2_go is loaded only at grant, so requester inputs cannot disturb it
    always_ff @(posedge clk) begin
        if (rst) begin
            l2_go   <= '0;
            i_rdata <= '0;
            d_rdata <= '0;
            i_resp  <= 1'b0;
            d_resp  <= 1'b0;
        end else begin
            i_resp <= 1'b0;
            d_resp <= 1'b0;
            if (grant_en) begin
                if (grant_d) begin
                    l2_go.mem_address <= d_address & ADDR_MASK;
                    l2_go.mem_wdata   <= d_wdata;
                    l2_go.mem_read    <= d_read & ~d_write;
                    l2_go.mem_write   <= d_write;
                end else begin
                    l2_go.mem_address <= i_address & ADDR_MASK;
                    l2_go.mem_wdata   <= '0;
                    l2_go.mem_read    <= 1'b1;
                    l2_go.mem_write   <= 1'b0;
                end
            end
            if (ret_hit) begin
                l2_go.mem_read  <= 1'b0;
                l2_go.mem_write <= 1'b0;
                if (state == SERVE_I) begin
                    i_rdata <= l2_ret.mem_rdata;
                    i_resp  <= 1'b1;
                end else begin
                    d_rdata <= l2_ret.mem_rdata;
                    d_resp  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_l2_arbiter.sv
// Self-checking bench for l2_arbiter: directed table, corner sequences,
// and random transactions against a transaction-level model.
module tb_l2_arbiter;
    import rv32i_types::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  i_address, d_address;
    logic         i_read, d_read, d_write;
    logic [255:0] i_rdata, d_rdata, d_wdata;
    logic         i_resp, d_resp;
    l2_go_t       l2_go;
    l2_ret_t      l2_ret;

    l2_arbiter #(.s_offset(5), .s_line(256)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_address (i_address),
        .i_read    (i_read),
        .i_rdata   (i_rdata),
        .i_resp    (i_resp),
        .d_address (d_address),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_resp    (d_resp),
        .l2_go     (l2_go),
        .l2_ret    (l2_ret)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total    = 0;

    logic         m_last_d;
    logic [255:0] m_i_line, m_d_line;

    typedef struct {
        logic         ireq, drd, dwr;
        logic [31:0]  ia, da;
        logic [255:0] wd;
        int           lat;
        logic [255:0] line;
        logic         exp_d;
        logic [31:0]  exp_addr;
        logic         exp_rd, exp_wr;
    } vec_t;

    vec_t vt[7];

    task automatic chk(input string name,
                       input logic [255:0] act,
                       input logic [255:0] exp);
        total++;
        if (act === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] r;
        for (int w = 0; w < 8; w++)
            r[w*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic run_txn(input string tag,
                           input logic ireq, drd, dwr,
                           input logic [31:0] ia, da,
                           input logic [255:0] wd,
                           input int lat,
                           input logic [255:0] line,
                           input logic exp_d,
                           input logic [31:0] exp_addr,
                           input logic exp_rd, exp_wr);
        logic stable;
        i_read    = ireq;
        d_read    = drd;
        d_write   = dwr;
        i_address = ia;
        d_address = da;
        d_wdata   = wd;
        @(negedge clk);
        chk({tag, " addr"}, l2_go.mem_address, exp_addr);
        chk({tag, " read"}, l2_go.mem_read, exp_rd);
        chk({tag, " write"}, l2_go.mem_write, exp_wr);
        if (exp_wr)
            chk({tag, " wdata"}, l2_go.mem_wdata, wd);
        chk({tag, " early resp"}, {i_resp, d_resp}, 2'b00);
        i_address = $urandom;
        d_address = $urandom;
        d_wdata   = rand_line();
        stable    = 1'b1;
        for (int c = 1; c < lat; c++) begin
            @(negedge clk);
            if (l2_go.mem_address !== exp_addr ||
                l2_go.mem_read !== exp_rd ||
                l2_go.mem_write !== exp_wr ||
                i_resp !== 1'b0 || d_resp !== 1'b0)
                stable = 1'b0;
        end
        chk({tag, " go stable"}, stable, 1'b1);
        l2_ret.mem_resp  = 1'b1;
        l2_ret.mem_rdata = line;
        @(negedge clk);
        l2_ret.mem_resp  = 1'b0;
        l2_ret.mem_rdata = rand_line();
        if (exp_d)
            m_d_line = line;
        else
            m_i_line = line;
        m_last_d = exp_d;
        chk({tag, " i_resp"}, i_resp, !exp_d);
        chk({tag, " d_resp"}, d_resp, exp_d);
        chk({tag, " i_rdata"}, i_rdata, m_i_line);
        chk({tag, " d_rdata"}, d_rdata, m_d_line);
        chk({tag, " go rw clr"},
            {l2_go.mem_read, l2_go.mem_write}, 2'b00);
        i_read  = 1'b0;
        d_read  = 1'b0;
        d_write = 1'b0;
        @(negedge clk);
        chk({tag, " resp once"}, {i_resp, d_resp}, 2'b00);
        chk({tag, " i hold"}, i_rdata, m_i_line);
        chk({tag, " d hold"}, d_rdata, m_d_line);
    endtask

    task automatic rand_txn(input int n);
        logic         ireq, dreq, drd, dwr, exp_d;
        logic [31:0]  ia, da, ea;
        int           kind;
        ireq = $urandom_range(0, 1);
        dreq = $urandom_range(0, 1);
        if (!ireq && !dreq)
            ireq = 1'b1;
        kind = $urandom_range(0, 2);
        drd  = dreq && (kind != 1);
        dwr  = dreq && (kind != 0);
        ia   = $urandom;
        da   = $urandom;
`ifdef L2_ARB_RR_EN
        exp_d = (ireq && dreq) ? !m_last_d : dreq;
`else
        exp_d = dreq;
`endif
        ea = exp_d ? da : ia;
        ea = ea - (ea % 32);
        run_txn($sformatf("rnd%0d", n), ireq, drd, dwr, ia, da,
                rand_line(), $urandom_range(1, 6), rand_line(),
                exp_d, ea, exp_d ? (drd && !dwr) : 1'b1,
                exp_d ? dwr : 1'b0);
    endtask

    initial begin
        logic [255:0] a5, pat, dead;
        logic [255:0] r;
        a5   = {32{8'hA5}};
        pat  = {4{64'h0123_4567_89AB_CDEF}};
        dead = {8{32'hDEAD_BEEF}};
        vt[0] = '{1, 0, 0, 32'h0000_1234, 0, 0, 4, a5,
                  0, 32'h0000_1220, 1, 0};
        vt[1] = '{0, 0, 1, 0, 32'h8000_0040, pat, 2, rand_line(),
                  1, 32'h8000_0040, 0, 1};
        vt[2] = '{0, 1, 0, 0, 32'h0000_0FFF, 0, 1, rand_line(),
                  1, 32'h0000_0FE0, 1, 0};
        vt[3] = '{0, 1, 1, 0, 32'h0000_0010, dead, 3, rand_line(),
                  1, 32'h0000_0000, 0, 1};
        for (int t = 4; t < 7; t++) begin
`ifdef L2_ARB_RR_EN
            vt[t] = '{1, 1, 0, 32'h100, 32'h204, 0, 2, rand_line(),
                      (t == 5), (t == 5) ? 32'h200 : 32'h100,
                      1, 0};
`else
            vt[t] = '{1, 1, 0, 32'h100, 32'h204, 0, 2, rand_line(),
                      1, 32'h200, 1, 0};
`endif
        end

        rst = 1'b1;
        i_read = 0; d_read = 0; d_write = 0;
        i_address = 0; d_address = 0; d_wdata = 0;
        l2_ret = '0;
        m_last_d = 1'b1;
        m_i_line = '0;
        m_d_line = '0;
        repeat (3) @(negedge clk);
        chk("rst go", l2_go, '0);
        chk("rst resp", {i_resp, d_resp}, 2'b00);
        chk("rst i_rdata", i_rdata, '0);
        chk("rst d_rdata", d_rdata, '0);
        rst = 1'b0;

        for (int t = 0; t < 7; t++)
            run_txn($sformatf("vec%0d", t), vt[t].ireq, vt[t].drd,
                    vt[t].dwr, vt[t].ia, vt[t].da, vt[t].wd,
                    vt[t].lat, vt[t].line, vt[t].exp_d,
                    vt[t].exp_addr, vt[t].exp_rd, vt[t].exp_wr);

        i_read    = 1'b1;
        i_address = 32'h0000_4444;
        @(negedge clk);
        chk("mid rst pre", l2_go.mem_read, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        i_read = 1'b0;
        m_i_line = '0;
        m_d_line = '0;
        m_last_d = 1'b1;
        chk("mid rst rw", {l2_go.mem_read, l2_go.mem_write}, 2'b00);
        chk("mid rst resp", {i_resp, d_resp}, 2'b00);
        l2_ret.mem_resp = 1'b1;
        @(negedge clk);
        l2_ret.mem_resp = 1'b0;
        chk("mid rst no resp", {i_resp, d_resp}, 2'b00);
        chk("stray go rw", {l2_go.mem_read, l2_go.mem_write}, 2'b00);
        @(negedge clk);
        chk("stray idle", {i_resp, d_resp}, 2'b00);
        r = rand_line();
        run_txn("after rst", 1, 0, 0, 32'h0000_4444, 0, 0, 2, r,
                0, 32'h0000_4440, 1, 0);

        for (int n = 0; n < 40; n++)
            rand_txn(n);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
